// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Optional build macro: MEM_ARB_ALIGN_CHECK_EN adds the misaligned-request
// error owner states used by the arbiter when alignment checking is enabled.

package mem_arb_pkg;

  // Byte address to word index shift (32-bit words).
  localparam int WORD_SHIFT   = 2;

  // Width of the IF starvation counter; wide enough for STARVE_MAX up to 15.
  localparam int STARVE_CNT_W = 4;

  // Owner of the memory port response slot in the following cycle.
`ifdef MEM_ARB_ALIGN_CHECK_EN
  typedef enum logic [2:0] {
    OWN_NONE   = 3'd0,
    OWN_IF_RD  = 3'd1,
    OWN_D_RD   = 3'd2,
    OWN_D_WR   = 3'd3,
    OWN_IF_ERR = 3'd4,
    OWN_D_ERR  = 3'd5
  } owner_e;
`else
  typedef enum logic [2:0] {
    OWN_NONE  = 3'd0,
    OWN_IF_RD = 3'd1,
    OWN_D_RD  = 3'd2,
    OWN_D_WR  = 3'd3
  } owner_e;
`endif

  // True when the low byte-offset bits of an address are non-zero.
  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return lo_bits != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// IF starvation counter for the memory port arbiter.
// Counts consecutive cycles in which IF requests but loses arbitration and
// raises force_if once the count reaches STARVE_MAX, handing IF the port.

`ifndef MEM_ARB_FF
// Register with synchronous active-high reset on cpu_rst.
// NOTE: sequential state uses non-blocking assignments so every register
// samples pre-edge values; the reset branch is sampled on the clock edge only.
`define MEM_ARB_FF(q, d, rst_val) \
  always_ff @(posedge clk) begin  \
    if (cpu_rst) q <= (rst_val);  \
    else         q <= (d);        \
  end
`endif

module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic cpu_rst,
  input  logic if_valid,
  input  logic if_grant,
  output logic force_if
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Next count: clear on IF grant or no IF request, else count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_valid || if_grant) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  `MEM_ARB_FF(cnt_q, cnt_d, '0)

  assign force_if = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single behavioural memory port.
// IF (instruction fetch, read-only) and D (load/store) share the port; D has
// priority unless IF has been starved for STARVE_MAX cycles. Granted requests
// go to memory in the grant cycle and the registered owner routes the
// one-cycle-later response back to the issuing requester.
// Optional build macro: MEM_ARB_ALIGN_CHECK_EN adds if_rsp_err/d_rsp_err and
// turns misaligned requests into error responses instead of memory accesses.

`ifndef MEM_ARB_FF
// Register with synchronous active-high reset on cpu_rst.
// NOTE: sequential state uses non-blocking assignments so every register
// samples pre-edge values; the reset branch is sampled on the clock edge only.
`define MEM_ARB_FF(q, d, rst_val) \
  always_ff @(posedge clk) begin  \
    if (cpu_rst) q <= (rst_val);  \
    else         q <= (d);        \
  end
`endif

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRWIDTH  = 32,
  parameter int BUSWIDTH   = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 cpu_rst,
  // Instruction fetch requester
  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [ADDRWIDTH-1:0] if_req_addr,
  output logic                 if_rsp_valid,
  output logic [BUSWIDTH-1:0]  if_rsp_data,
  // Data load/store requester
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic [ADDRWIDTH-1:0] d_req_addr,
  input  logic                 d_req_wren,
  input  logic [BUSWIDTH-1:0]  d_req_wdata,
  output logic                 d_rsp_valid,
  output logic [BUSWIDTH-1:0]  d_rsp_data,
`ifdef MEM_ARB_ALIGN_CHECK_EN
  output logic                 if_rsp_err,
  output logic                 d_rsp_err,
`endif
  // Memory side
  output logic [ADDRWIDTH-1:0] mem_rd_addr,
  output logic [ADDRWIDTH-1:0] mem_wr_addr,
  output logic [BUSWIDTH-1:0]  mem_wr_data,
  output logic                 mem_wren,
  input  logic [BUSWIDTH-1:0]  mem_rd_data
);

  logic force_if;
  logic if_grant;
  logic d_grant;
  logic if_bad;
  logic d_bad;
  logic issue_if_rd;
  logic issue_d_rd;
  logic issue_d_wr;

  owner_e owner_q;
  owner_e owner_d;

  logic [ADDRWIDTH-1:0] rd_addr_q;
  logic [ADDRWIDTH-1:0] wr_addr_q;
  logic [BUSWIDTH-1:0]  wr_data_q;
  logic [ADDRWIDTH-1:0] if_word;
  logic [ADDRWIDTH-1:0] d_word;

  assign if_word = if_req_addr >> WORD_SHIFT;
  assign d_word  = d_req_addr  >> WORD_SHIFT;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign if_bad = is_misaligned(if_req_addr[1:0]);
  assign d_bad  = is_misaligned(d_req_addr[1:0]);
`else
  // Byte offsets are deliberately dropped in this build.
  logic unused_lo_bits;
  assign unused_lo_bits = ^{if_req_addr[1:0], d_req_addr[1:0]};
  assign if_bad = 1'b0;
  assign d_bad  = 1'b0;
`endif

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .cpu_rst  (cpu_rst),
    .if_valid (if_req_valid),
    .if_grant (if_grant),
    .force_if (force_if)
  );

  // Grant selection: D wins by default, IF wins alone or when starved; no
  // grants while reset is asserted.
  always_comb begin
    if_grant = 1'b0;
    d_grant  = 1'b0;
    if (!cpu_rst) begin
      if (if_req_valid && (force_if || !d_req_valid)) begin
        if_grant = 1'b1;
      end else if (d_req_valid) begin
        d_grant = 1'b1;
      end
    end
  end

  assign if_req_ready = if_grant;
  assign d_req_ready  = d_grant;

  // Decide what the grant does this cycle and who owns next cycle's response.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    issue_if_rd = 1'b0;
    issue_d_rd  = 1'b0;
    issue_d_wr  = 1'b0;
    owner_d     = OWN_NONE;
    if (if_grant) begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if (if_bad) begin
        owner_d = OWN_IF_ERR;
      end else
`endif
      begin
        issue_if_rd = 1'b1;
        owner_d     = OWN_IF_RD;
      end
    end else if (d_grant) begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if (d_bad) begin
        owner_d = OWN_D_ERR;
      end else
`endif
      if (d_req_wren) begin
        issue_d_wr = 1'b1;
        owner_d    = OWN_D_WR;
      end else begin
        issue_d_rd = 1'b1;
        owner_d    = OWN_D_RD;
      end
    end
  end

  // Memory request: new values in an issue cycle, otherwise hold the last ones.
  always_comb begin
    mem_rd_addr = rd_addr_q;
    mem_wr_addr = wr_addr_q;
    mem_wr_data = wr_data_q;
    mem_wren    = issue_d_wr;
    if (issue_if_rd) begin
      mem_rd_addr = if_word;
    end else if (issue_d_rd) begin
      mem_rd_addr = d_word;
    end
    if (issue_d_wr) begin
      mem_wr_addr = d_word;
      mem_wr_data = d_req_wdata;
    end
  end

  // Last issued memory address/data, held across idle cycles.
  `MEM_ARB_FF(rd_addr_q, mem_rd_addr, '0)
  `MEM_ARB_FF(wr_addr_q, mem_wr_addr, '0)
  `MEM_ARB_FF(wr_data_q, mem_wr_data, '0)

  // Response owner, loaded from every cycle's grant outcome.
  `MEM_ARB_FF(owner_q, owner_d, OWN_NONE)

  // Response routing from the owner register; reset drops a pending response.
  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    d_rsp_valid  = 1'b0;
    d_rsp_data   = '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    if_rsp_err   = 1'b0;
    d_rsp_err    = 1'b0;
`endif
    if (!cpu_rst) begin
      case (owner_q)
        OWN_IF_RD: begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = mem_rd_data;
        end
        OWN_D_RD: begin
          d_rsp_valid = 1'b1;
          d_rsp_data  = mem_rd_data;
        end
        OWN_D_WR: begin
          d_rsp_valid = 1'b1;
        end
`ifdef MEM_ARB_ALIGN_CHECK_EN
        OWN_IF_ERR: begin
          if_rsp_valid = 1'b1;
          if_rsp_err   = 1'b1;
        end
        OWN_D_ERR: begin
          d_rsp_valid = 1'b1;
          d_rsp_err   = 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single behavioural memory port between two requesters: core instruction fetch (IF) and the data load/store path (D).
- Arbitrates every cycle. Converts byte addresses to word indices. Routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between the core's fetch/LSU logic and the mem instance (mem_intf.mem modport side).

Parameters:
- ADDRWIDTH, 32, byte-address width of the requester and memory address buses
- BUSWIDTH, 32, data width
- STARVE_MAX, 4, number of consecutive cycles IF may lose arbitration before it is force-granted (range 1..15)

Ports:
- clk  in  1  core clock
- cpu_rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  ADDRWIDTH  IF byte address
- if_rsp_valid  out  1  IF read data valid
- if_rsp_data  out  BUSWIDTH  IF read data
- d_req_valid  in  1  D request
- d_req_ready  out  1  D request accepted this cycle
- d_req_addr  in  ADDRWIDTH  D byte address
- d_req_wren  in  1  1 = write, 0 = read
- d_req_wdata  in  BUSWIDTH  D write data
- d_rsp_valid  out  1  D response: read data, or write acknowledge
- d_rsp_data  out  BUSWIDTH  D read data (0 for a write acknowledge)
- mem_rd_addr  out  ADDRWIDTH  word index to memory
- mem_wr_addr  out  ADDRWIDTH  word index to memory
- mem_wr_data  out  BUSWIDTH  memory write data
- mem_wren  out  1  memory write enable
- mem_rd_data  in  BUSWIDTH  memory read data; registered in memory, valid 1 cycle after address

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (cpu_rst sampled on posedge clk).
- Reset values: all ready, rsp_valid and mem_wren outputs are 0; rsp_data, mem addresses and mem_wr_data are 0; starve_cnt = 0; owner state = OWN_NONE.
- Ready outputs are 0 while cpu_rst is high.
- Arbitration (combinational, per cycle):
  - D has fixed priority over IF, except when starve_cnt == STARVE_MAX; then IF wins.
  - Exactly one ready is asserted when any valid is high. Neither is asserted when both valids are low.
  - A grant is a valid&ready handshake in that cycle. The request is issued to memory in the same cycle.
- Address rules:
  - mem_rd_addr / mem_wr_addr = granted byte address >> 2, zero-extended to ADDRWIDTH.
  - Bits [1:0] are ignored (but see the optional feature).
- Write grant (D, d_req_wren = 1):
  - mem_wren = 1 and mem_wr_data = d_req_wdata in the grant cycle.
  - d_rsp_valid = 1 in the next cycle, with d_rsp_data = 0.
- Read grant:
  - mem_wren = 0 and mem_rd_addr is driven in the grant cycle.
  - The next cycle, the matching rsp_valid = 1 and rsp_data = mem_rd_data.
- Owner register (registered): OWN_NONE / OWN_IF_RD / OWN_D_RD / OWN_D_WR.
  - Loaded each cycle from that cycle's grant (OWN_NONE if no grant).
  - Responses are decoded from the owner register only.
  - Back-to-back grants give one response per cycle with no bubble.
- Idle cycles: mem_rd_addr holds its last value, and mem_wren = 0.
- starve_cnt:
  - Increments when if_req_valid = 1 and IF is not granted.
  - Clears to 0 on an IF grant, or when if_req_valid = 0.
  - Saturates at STARVE_MAX.
- Both valids high with starve_cnt < STARVE_MAX: D is granted, and IF's request must be held stable by the requester.
- Reset mid-operation: an outstanding response is dropped. No rsp_valid is asserted in the cycle after cpu_rst deasserts unless a new grant occurred.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - Adds output ports if_rsp_err and d_rsp_err (1 bit each).
  - A granted request with addr[1:0] != 0 is accepted (ready = 1) but NOT issued: mem_wren = 0, and mem addresses are unchanged.
  - Next cycle: rsp_valid = 1, rsp_err = 1, rsp_data = 0. Owner states OWN_IF_ERR / OWN_D_ERR are added.
- Not defined:
  - No err ports exist.
  - Low address bits are silently dropped, as described in Behaviour.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum (OWN_NONE, OWN_IF_RD, OWN_D_RD, OWN_D_WR, plus the err states under the macro)
  - WORD_SHIFT = 2
  - STARVE_CNT_W = 4
- Sub-module mem_arb_starve_ctr: starve counter plus force-grant flag, parameterised by STARVE_MAX. The arbiter top holds the grant logic, owner register and response mux.
- FF registers use the team FF macro, adapted to active-high synchronous reset.

Test Plan:
- IF only, if_req_addr = 0x10 with memory word 4 = 0xDEADBEEF → mem_rd_addr = 4 in the grant cycle; if_rsp_valid = 1 and data 0xDEADBEEF one cycle later; d_rsp_valid stays 0.
- D write to addr 0x20, wdata 0x12345678, then D read of 0x20 → mem_wren = 1 with mem_wr_addr = 8; ack with d_rsp_data = 0; the read returns 0x12345678 two cycles after the write grant.
- Both valid continuously, STARVE_MAX = 4 → D granted 4 cycles, IF granted on the 5th; the pattern repeats 4:1; every response is routed to the correct requester.
- Alternating IF and D reads on consecutive cycles → one response per cycle, no bubble, no cross-routing.
- cpu_rst asserted in the cycle after an IF read grant → if_rsp_valid = 0; the counter and owner read 0/OWN_NONE after reset.
- MEM_ARB_ALIGN_CHECK_EN defined, IF addr 0x6 → if_req_ready = 1, mem_rd_addr unchanged; the next cycle gives if_rsp_valid = 1, if_rsp_err = 1, data 0.
